// File: rtl/sonar_pkg.sv
// Shared sonar receive-path definitions: detector state encoding and
// the default sample/time widths used by the beamformer and time_of_flight.
package sonar_pkg;

    localparam int DEF_TIME_WIDTH   = 24;
    localparam int DEF_SAMPLE_WIDTH = 16;
    localparam int MIDSCALE         = 32768;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BLANK   = 3'd1,
        ARMED   = 3'd2,
        CONFIRM = 3'd3,
        PEAK    = 3'd4,
        DONE    = 3'd5
    } echo_state_t;

endpackage

// File: rtl/echo_magnitude.sv
// Stage 1 of the echo detector: offset-binary sample to magnitude about
// midscale, registered together with its valid and capture timestamp.
module echo_magnitude
    import sonar_pkg::*;
#(
    parameter int TIME_WIDTH   = DEF_TIME_WIDTH,
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int MID_LEVEL    = MIDSCALE
)(
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    flush_in,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    sample_valid_in,
    input  logic [TIME_WIDTH-1:0]   time_in,
    output logic [SAMPLE_WIDTH-1:0] mag_out,
    output logic                    valid_out,
    output logic [TIME_WIDTH-1:0]   time_out
);

    localparam logic [SAMPLE_WIDTH-1:0] MID_V = SAMPLE_WIDTH'(MID_LEVEL);

    logic [SAMPLE_WIDTH-1:0] w_mag;
    logic [SAMPLE_WIDTH-1:0] r_mag;
    logic                    r_valid;
    logic [TIME_WIDTH-1:0]   r_time;

    // Largest magnitude is midscale itself (sample 0), so no extra bit is needed.
    always_comb begin
        if (sample_in >= MID_V) begin
            w_mag = sample_in - MID_V;
        end else begin
            w_mag = MID_V - sample_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_mag   <= '0;
            r_valid <= 1'b0;
            r_time  <= '0;
        end else begin
            r_valid <= sample_valid_in && !flush_in;
            if (sample_valid_in) begin
                r_mag  <= w_mag;
                r_time <= time_in;
            end
        end
    end

    assign mag_out   = r_mag;
    assign valid_out = r_valid;
    assign time_out  = r_time;

endmodule

// File: rtl/echo_detector.sv
// Echo detector: blanking after each ping, run-length confirmation of
// over-threshold magnitudes, first-sample timestamp, windowed peak and miss timeout.
module echo_detector
    import sonar_pkg::*;
#(
    parameter int TIME_WIDTH      = DEF_TIME_WIDTH,
    parameter int SAMPLE_WIDTH    = DEF_SAMPLE_WIDTH,
    parameter int BLANK_CYCLES    = 600000,
    parameter int CONFIRM_SAMPLES = 4,
    parameter int PEAK_SAMPLES    = 32,
    parameter int LISTEN_CYCLES   = 16000000
)(
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    burst_start_in,
    input  logic [TIME_WIDTH-1:0]   time_since_emission_in,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    sample_valid_in,
    input  logic [SAMPLE_WIDTH-1:0] threshold_in,
    output logic                    echo_detected_out,
    output logic [TIME_WIDTH-1:0]   echo_time_out,
    output logic                    echo_valid_out,
    output logic [SAMPLE_WIDTH-1:0] peak_out,
    output logic                    peak_valid_out,
    output logic                    timeout_out,
    output echo_state_t             state_dbg_out
);

    localparam int CNT_W = $clog2(PEAK_SAMPLES + 1);
    localparam logic [CNT_W-1:0] CONFIRM_N = CNT_W'(CONFIRM_SAMPLES);
    localparam logic [CNT_W-1:0] PEAK_N    = CNT_W'(PEAK_SAMPLES);

    logic [SAMPLE_WIDTH-1:0] w_mag;
    logic                    w_s1_valid;
    logic [TIME_WIDTH-1:0]   w_s1_time;
    logic                    w_over;
    logic [CNT_W-1:0]        w_cnt_inc;
    logic [SAMPLE_WIDTH-1:0] w_peak_max;
    logic                    w_blank_done;
    logic                    w_listen_over;

    echo_state_t             r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [SAMPLE_WIDTH-1:0] r_peak;
    logic [TIME_WIDTH-1:0]   r_run_time;
    logic                    r_detected;
    logic [TIME_WIDTH-1:0]   r_echo_time;
    logic                    r_echo_valid;
    logic [SAMPLE_WIDTH-1:0] r_peak_out;
    logic                    r_peak_valid;
    logic                    r_timeout;

    echo_magnitude #(
        .TIME_WIDTH   (TIME_WIDTH),
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .MID_LEVEL    (MIDSCALE)
    ) u_mag (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .flush_in        (burst_start_in),
        .sample_in       (sample_in),
        .sample_valid_in (sample_valid_in),
        .time_in         (time_since_emission_in),
        .mag_out         (w_mag),
        .valid_out       (w_s1_valid),
        .time_out        (w_s1_time)
    );

    assign w_over        = w_s1_valid && (w_mag > threshold_in);
    assign w_cnt_inc     = r_cnt + 1'b1;
    assign w_peak_max    = (w_mag > r_peak) ? w_mag : r_peak;
    assign w_blank_done  = time_since_emission_in >= TIME_WIDTH'(BLANK_CYCLES);
    assign w_listen_over = time_since_emission_in >= TIME_WIDTH'(LISTEN_CYCLES);

    // r_cnt counts valid samples from the first run sample, so it serves both
    // the confirmation run and the peak window; it is zero whenever ARMED.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_peak       <= '0;
            r_run_time   <= '0;
            r_detected   <= 1'b0;
            r_echo_time  <= '0;
            r_echo_valid <= 1'b0;
            r_peak_out   <= '0;
            r_peak_valid <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_echo_valid <= 1'b0;
            r_peak_valid <= 1'b0;
            r_timeout    <= 1'b0;
            if (burst_start_in) begin
                r_state     <= BLANK;
                r_cnt       <= '0;
                r_peak      <= '0;
                r_run_time  <= '0;
                r_detected  <= 1'b0;
                r_echo_time <= '0;
                r_peak_out  <= '0;
            end else begin
                case (r_state)
                    IDLE: ;
                    BLANK: begin
                        if (w_blank_done) r_state <= ARMED;
                    end
                    ARMED, CONFIRM: begin
                        if (w_over && (w_cnt_inc == CONFIRM_N)) begin
                            r_echo_valid <= 1'b1;
                            r_detected   <= 1'b1;
                            r_echo_time  <= (r_cnt == '0) ? w_s1_time : r_run_time;
                            r_cnt        <= w_cnt_inc;
                            r_peak       <= w_peak_max;
                            r_state      <= PEAK;
                        end else if (w_listen_over) begin
                            r_timeout <= 1'b1;
                            r_cnt     <= '0;
                            r_peak    <= '0;
                            r_state   <= DONE;
                        end else if (w_over) begin
                            if (r_cnt == '0) r_run_time <= w_s1_time;
                            r_cnt   <= w_cnt_inc;
                            r_peak  <= w_peak_max;
                            r_state <= CONFIRM;
                        end else if (w_s1_valid) begin
                            r_cnt   <= '0;
                            r_peak  <= '0;
                            r_state <= ARMED;
                        end
                    end
                    PEAK: begin
                        if (w_s1_valid) begin
                            r_cnt  <= w_cnt_inc;
                            r_peak <= w_peak_max;
                            if (w_cnt_inc == PEAK_N) begin
                                r_peak_out   <= w_peak_max;
                                r_peak_valid <= 1'b1;
                                r_state      <= DONE;
                            end
                        end
                    end
                    DONE: ;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign echo_detected_out = r_detected;
    assign echo_time_out     = r_echo_time;
    assign echo_valid_out    = r_echo_valid;
    assign peak_out          = r_peak_out;
    assign peak_valid_out    = r_peak_valid;
    assign timeout_out       = r_timeout;
    assign state_dbg_out     = r_state;

endmodule

// File: tb/tb_echo_detector.sv
// Bench for echo_detector: directed pings checked every cycle against a
// sample-level model, plus literal expectations from the hand-worked cases.
module tb_echo_detector;
    import sonar_pkg::*;

    localparam int TW      = 24;
    localparam int SW      = 16;
    localparam int BLANK_C = 600000;
    localparam int CONF    = 4;
    localparam int PEAKN   = 32;
    localparam int LISTEN  = 16000000;

    logic          clk = 1'b0;
    logic          rst;
    logic          burst;
    logic [TW-1:0] tse;
    logic [SW-1:0] smp;
    logic          sv;
    logic [SW-1:0] thr;
    logic          echo_detected;
    logic [TW-1:0] echo_time;
    logic          echo_valid;
    logic [SW-1:0] peak;
    logic          peak_valid;
    logic          timeout;
    echo_state_t   state_dbg;

    always #5 clk = ~clk;

    echo_detector dut (
        .clk_in                 (clk),
        .rst_in                 (rst),
        .burst_start_in         (burst),
        .time_since_emission_in (tse),
        .sample_in              (smp),
        .sample_valid_in        (sv),
        .threshold_in           (thr),
        .echo_detected_out      (echo_detected),
        .echo_time_out          (echo_time),
        .echo_valid_out         (echo_valid),
        .peak_out               (peak),
        .peak_valid_out         (peak_valid),
        .timeout_out            (timeout),
        .state_dbg_out          (state_dbg)
    );

    int n_checks = 0;
    int n_errors = 0;
    int ev_cnt = 0;
    int pv_cnt = 0;
    int to_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int mag_of(input logic [SW-1:0] s);
        int d;
        d = int'(s) - 32768;
        return (d < 0) ? -d : d;
    endfunction

    // Model: the sample seen at one edge is judged at the next edge, and the
    // current run (then peak window) is just the list of its magnitudes.
    echo_state_t m_state;
    int          run_q[$];
    int          m_run_t;
    logic        m_det, m_ev, m_pv, m_to;
    int          m_etime, m_peak;
    logic        p_v = 1'b0;
    int          p_mag = 0;
    int          p_t = 0;

    always @(posedge clk) begin : model
        int mx;
        m_ev = 1'b0;
        m_pv = 1'b0;
        m_to = 1'b0;
        if (rst) begin
            m_state = IDLE;
            m_det = 1'b0; m_etime = 0; m_peak = 0; m_run_t = 0;
            run_q.delete();
            p_v = 1'b0;
        end else if (burst) begin
            m_state = BLANK;
            m_det = 1'b0; m_etime = 0; m_peak = 0;
            run_q.delete();
            p_v = 1'b0;
        end else begin
            case (m_state)
                BLANK: if (int'(tse) >= BLANK_C) m_state = ARMED;
                ARMED, CONFIRM: begin
                    if (p_v) begin
                        if (p_mag > int'(thr)) begin
                            if (run_q.size() == 0) m_run_t = p_t;
                            run_q.push_back(p_mag);
                        end else begin
                            run_q.delete();
                        end
                    end
                    if (run_q.size() == CONF) begin
                        m_ev = 1'b1; m_det = 1'b1; m_etime = m_run_t;
                        m_state = PEAK;
                    end else if (int'(tse) >= LISTEN) begin
                        m_to = 1'b1;
                        run_q.delete();
                        m_state = DONE;
                    end else if (run_q.size() > 0) begin
                        m_state = CONFIRM;
                    end else begin
                        m_state = ARMED;
                    end
                end
                PEAK: begin
                    if (p_v) begin
                        run_q.push_back(p_mag);
                        if (run_q.size() == PEAKN) begin
                            mx = 0;
                            foreach (run_q[i]) if (run_q[i] > mx) mx = run_q[i];
                            m_peak = mx; m_pv = 1'b1;
                            m_state = DONE;
                        end
                    end
                end
                default: ;
            endcase
            p_v = sv;
            p_mag = mag_of(smp);
            p_t = int'(tse);
        end
    end

    always @(negedge clk) begin : compare
        check("state", state_dbg, m_state);
        check("echo_detected", echo_detected, m_det);
        check("echo_time", echo_time, m_etime);
        check("echo_valid", echo_valid, m_ev);
        check("peak", peak, m_peak);
        check("peak_valid", peak_valid, m_pv);
        check("timeout", timeout, m_to);
        ev_cnt += int'(echo_valid);
        pv_cnt += int'(peak_valid);
        to_cnt += int'(timeout);
    end

    task automatic cyc(input logic v, input int s, input int t);
        sv  = v;
        smp = s[SW-1:0];
        tse = t[TW-1:0];
        @(negedge clk);
    endtask

    task automatic send(input int s, input int t);
        cyc(1'b1, s, t);
        cyc(1'b0, 32768, t + 1);
        cyc(1'b0, 32768, t + 2);
    endtask

    task automatic burst_cyc(input logic v, input int s);
        burst = 1'b1;
        cyc(v, s, 0);
        burst = 1'b0;
    endtask

    int br[11] = '{40000, 40000, 32768, 30000, 30000, 30000, 30000, 25000, 25000, 25000, 25000};
    int snap;

    initial begin
        rst = 1'b1; burst = 1'b0; tse = '0; smp = 16'd32768; sv = 1'b0; thr = 16'd5000;
        repeat (3) @(negedge clk);
        check("rst_state", state_dbg, IDLE);
        check("rst_detected", echo_detected, 0);
        check("rst_peak", peak, 0);
        check("rst_timeout", timeout, 0);
        rst = 1'b0;

        // Blanking: strong samples inside the window are ignored.
        burst_cyc(1'b0, 32768);
        send(65535, 1000);
        send(65535, 500000);
        check("blank_state", state_dbg, BLANK);
        check("blank_no_echo", ev_cnt, 0);
        cyc(1'b0, 32768, 599999);
        check("blank_edge_state", state_dbg, BLANK);
        cyc(1'b0, 32768, 600000);
        check("armed_state", state_dbg, ARMED);

        // Clean echo, then the peak window with a full-scale negative sample.
        send(32768, 700000);
        send(40000, 700100);
        send(41000, 700200);
        send(42000, 700300);
        check("clean_confirm_state", state_dbg, CONFIRM);
        cyc(1'b1, 43000, 700400);
        check("clean_ev_early", echo_valid, 0);
        cyc(1'b0, 32768, 700401);
        check("clean_ev", echo_valid, 1);
        check("clean_time", echo_time, 700100);
        check("clean_det", echo_detected, 1);
        cyc(1'b0, 32768, 700402);
        check("clean_ev_drop", echo_valid, 0);
        check("clean_det_hold", echo_detected, 1);
        for (int i = 5; i <= 31; i++) send((i == 12) ? 0 : 40000 + i * 10, 700000 + 100 * i);
        check("peak_none_early", pv_cnt, 0);
        cyc(1'b1, 41000, 703200);
        check("peak_pv_early", peak_valid, 0);
        cyc(1'b0, 32768, 703201);
        check("peak_pv", peak_valid, 1);
        check("peak_val", peak, 32768);
        cyc(1'b0, 32768, 703202);
        cyc(1'b0, 32768, 703203);
        check("peak_count", pv_cnt, 1);
        check("peak_done_state", state_dbg, DONE);
        check("peak_time_hold", echo_time, 700100);

        // Broken runs: only the 25000 run confirms, stamped at its first sample.
        burst_cyc(1'b0, 32768);
        cyc(1'b0, 32768, 600000);
        snap = ev_cnt;
        for (int i = 0; i < 11; i++) send(br[i], 800000 + 100 * i);
        check("broken_one_echo", ev_cnt - snap, 1);
        check("broken_time", echo_time, 800700);

        // Ping restart in the middle of the peak window.
        send(40000, 801100);
        cyc(1'b1, 40000, 801200);
        snap = pv_cnt;
        burst_cyc(1'b1, 45000);
        check("restart_state", state_dbg, BLANK);
        check("restart_det", echo_detected, 0);
        check("restart_time", echo_time, 0);
        check("restart_peak", peak, 0);
        send(0, 10);
        check("restart_no_pv", pv_cnt - snap, 0);

        // Confirmation on the same cycle the listen window expires.
        cyc(1'b0, 32768, 600000);
        send(20000, 15999000);
        send(20000, 15999100);
        send(20000, 15999200);
        snap = to_cnt;
        cyc(1'b1, 20000, 15999999);
        cyc(1'b0, 32768, 16000000);
        check("tie_ev", echo_valid, 1);
        check("tie_no_to", timeout, 0);
        cyc(1'b0, 32768, 16000001);
        check("tie_state", state_dbg, PEAK);
        check("tie_to_count", to_cnt - snap, 0);

        // Miss: nothing over threshold before the listen limit.
        burst_cyc(1'b0, 32768);
        cyc(1'b0, 32768, 600000);
        send(33000, 1000000);
        send(30000, 2000000);
        snap = to_cnt;
        cyc(1'b0, 32768, 15999999);
        check("miss_to_early", timeout, 0);
        cyc(1'b0, 32768, 16000000);
        check("miss_to", timeout, 1);
        check("miss_det", echo_detected, 0);
        cyc(1'b0, 32768, 16000001);
        check("miss_state", state_dbg, DONE);
        send(65535, 16000100);
        send(65535, 16000200);
        check("miss_to_count", to_cnt - snap, 1);
        check("miss_det_hold", echo_detected, 0);

        // Reset together with a ping start: reset wins.
        burst_cyc(1'b0, 32768);
        cyc(1'b0, 32768, 600000);
        for (int i = 0; i < 4; i++) send(50000, 700000 + 100 * i);
        check("pre_rst_det", echo_detected, 1);
        rst = 1'b1; burst = 1'b1;
        cyc(1'b1, 50000, 700500);
        rst = 1'b0; burst = 1'b0;
        check("rstb_state", state_dbg, IDLE);
        check("rstb_det", echo_detected, 0);
        check("rstb_time", echo_time, 0);
        check("rstb_peak", peak, 0);
        send(50000, 700600);
        check("rstb_stay_idle", state_dbg, IDLE);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/echo_detector.md
Name: echo_detector

Overview:
- Replaces the single-compare threshold on the receive-beamformer output. Consumes beamformed samples (aggregated waveform plus sample-valid) and ignores transmit ringing during a blanking window.
- Declares an echo only after a run of consecutive over-threshold samples. Timestamps the first sample of that run and tracks peak amplitude over a short window.
- Outputs feed time_of_flight (echo level and time) and the display and velocity path (peak).

Parameters:
- TIME_WIDTH, 24, width of time-since-emission counter
- SAMPLE_WIDTH, 16, beamformed sample width (unsigned, offset binary)
- MIDSCALE, 32768, zero-signal level subtracted before magnitude
- BLANK_CYCLES, 600000, clock cycles after burst start during which samples are ignored (exceeds 524288-cycle burst)
- CONFIRM_SAMPLES, 4, consecutive over-threshold valid samples required to declare echo
- PEAK_SAMPLES, 32, valid samples (counting from first run sample) over which peak is tracked
- LISTEN_CYCLES, 16000000, time after which an unanswered ping is declared a miss

Ports:
- clk_in  input  1  system clock, 100 MHz
- rst_in  input  1  synchronous active-high reset
- burst_start_in  input  1  one-cycle pulse at each ping start; restarts detection
- time_since_emission_in  input  TIME_WIDTH  cycles since burst start
- sample_in  input  SAMPLE_WIDTH  beamformed sample
- sample_valid_in  input  1  sample_in qualifier (about 1 MHz)
- threshold_in  input  SAMPLE_WIDTH  magnitude threshold, sampled live
- echo_detected_out  output  1  level; high from confirmation until next burst_start or reset
- echo_time_out  output  TIME_WIDTH  timestamp of first sample of confirming run
- echo_valid_out  output  1  one-cycle pulse on confirmation
- peak_out  output  SAMPLE_WIDTH  maximum magnitude over peak window
- peak_valid_out  output  1  one-cycle pulse when peak window closes
- timeout_out  output  1  one-cycle pulse when LISTEN_CYCLES elapse without echo

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- Pipeline stage 1 (echo_magnitude): registers the following.
  - mag = sample >= MIDSCALE ? sample-MIDSCALE : MIDSCALE-sample. This is 16 bit and max 32768, so there is no overflow.
  - Delayed valid, and time_since_emission_in captured with the sample.
- Stage 2: FSM. Over-threshold means mag > threshold_in (strict).
- States and transitions:
  - IDLE: wait for burst_start_in, then go to BLANK.
  - BLANK: all samples ignored. Go to ARMED when time_since_emission_in >= BLANK_CYCLES.
  - ARMED, on each valid:
    - Over-threshold: capture stage-1 timestamp, run_cnt=1, peak=mag. If CONFIRM_SAMPLES==1, confirm immediately; otherwise go to CONFIRM.
  - CONFIRM, on each valid:
    - Over-threshold: run_cnt++ and update peak. When run_cnt reaches CONFIRM_SAMPLES, confirm.
    - Under-threshold: clear run_cnt and peak, back to ARMED. The next run gets a fresh timestamp.
  - Confirm: echo_valid_out pulses and echo_detected_out is set. echo_time_out is driven with the captured timestamp, then go to PEAK.
  - PEAK: on each valid, peak = max(peak, mag) and win_cnt++. The window counts from the first run sample. When PEAK_SAMPLES samples have been seen: peak_out=peak, peak_valid_out pulses, go to DONE.
  - DONE: hold outputs, wait for burst_start_in.
- Latency: echo_valid_out is high exactly 2 cycles after the sample_valid_in cycle of the confirming sample. peak_valid_out is likewise 2 cycles after the closing sample.
- Timeout: in ARMED or CONFIRM, time_since_emission_in >= LISTEN_CYCLES causes timeout_out to pulse and the FSM to go to DONE, with echo outputs left at 0. If confirmation and timeout fall on the same cycle, confirmation wins and there is no timeout pulse.
- burst_start_in in any state, including mid-PEAK:
  - Next state BLANK.
  - echo_detected_out, echo_time_out, peak_out and all counters cleared.
  - Pulses suppressed that cycle.
  - Stage-1 valid is flushed.
- rst_in has priority over burst_start_in.
- Samples without valid never advance counters.
- threshold_in change mid-run takes effect on the next valid sample.

Decomposition:
- Package sonar_pkg holds:
  - the echo_state_t enum {IDLE, BLANK, ARMED, CONFIRM, PEAK, DONE};
  - MIDSCALE, and the default TIME_WIDTH and SAMPLE_WIDTH constants, shared with time_of_flight and receive_beamformer.
- Sub-module: echo_magnitude, the registered offset-binary to magnitude stage (stage 1) carrying valid and timestamp.

Test Plan:
- Blanking: burst_start at t=0; sample 65535 valid at time 1000 and 500000 -> no echo_valid_out; state reaches ARMED at time 600000.
- Clean echo: threshold 5000; after blank, valids with samples 32768,40000,41000,42000,43000 at times 700000,700100,700200,700300,700400 -> echo_valid_out 2 cycles after the 700400 valid; echo_time_out=700100; echo_detected_out stays high.
- Broken run: threshold 5000; samples 40000,40000,32768, then 4×30000 (mag 2768 < 5000), then 4×25000 (mag 7768) from time 800000 in 100-cycle steps -> a single confirmation, with echo_time_out equal to the time of the first 25000 sample.
- Peak/abs: confirmed run followed by a sample of 0 (mag 32768) inside the window -> peak_out=32768 and peak_valid_out on the 32nd window sample.
- Timeout: no over-threshold samples -> timeout_out pulses once when time reaches 16000000; echo_detected_out=0; no further pulses.
- burst_start mid-PEAK -> outputs cleared next cycle, no peak_valid_out; rst_in asserted at the same time as burst_start_in -> state IDLE, and all outputs 0.
